sirv_bootrom_icb: RTL and testbench
===================================

Name: sirv_bootrom_icb

Overview:
Parametrised boot ROM that replaces the fixed combinational mask ROM. It is an ICB slave with a registered, back-pressurable single-stage response. It supports DW=32 or DW=64 and two boot modes: jump-to-RAM and XIP. The boot target address is a parameter; the matching LUI/ADDI/JALR sequence is generated at elaboration. It sits on the PPI/boot region at reset-vector base 0x0000_1000.

Parameters:
AW, 12, ROM byte-offset address width (region size 2^AW bytes)
DW, 32, data width; legal values 32 or 64
DP, 1024, implemented depth in 32-bit words; DP*4 <= 2^AW
BOOT_MODE, 0, 0 = jump to RAM_BASE; 1 = XIP via config header to XIP_BASE
RAM_BASE, 32'h8000_0000, jump target for mode 0
XIP_BASE, 32'h2040_0000, jump target for mode 1
CFG_WORD, 32'h0000_6661, config word at word 3 in mode 1

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
i_icb_cmd_valid  in  1  command valid
i_icb_cmd_ready  out  1  command ready
i_icb_cmd_addr  in  AW  byte offset within ROM
i_icb_cmd_read  in  1  1 = read, 0 = write
i_icb_cmd_wdata  in  DW  ignored
i_icb_cmd_wmask  in  DW/8  ignored
i_icb_rsp_valid  out  1  response valid
i_icb_rsp_ready  in  1  response ready
i_icb_rsp_rdata  out  DW  read data
i_icb_rsp_err  out  1  error flag

Behaviour:
- Clock/reset: one clock clk. rst_n is synchronous and active-low, sampled only on the rising edge of clk.
- Reset values: rsp_valid=0, rsp_rdata=0, rsp_err=0. cmd_ready=1 once reset is released.
- cmd_ready = ~rsp_valid | rsp_ready. This is a one-entry output register with full throughput: one cmd per cycle when rsp_ready is held high.
- Accept occurs when cmd_valid & cmd_ready. On the next edge: rsp_valid=1, and rdata/err are loaded. Latency is exactly 1 cycle.
- Response hold: while rsp_valid & ~rsp_ready, rsp_valid, rdata and err hold stable.
- rsp_valid clears on rsp_ready unless a new cmd is accepted in the same cycle. Simultaneous accept and drain reloads the register with no bubble.
- Word index = addr[AW-1:2].
  - DW=64: rdata = {word[2k+1], word[2k]} with k = addr[AW-1:3].
  - addr[1:0] (and addr[2] when DW=64) are ignored within the beat.
- Write command: no state change, rdata=0, err=1.
- Out-of-range read (addr >= DP*4): rdata=0, err=1.
- Encodings, with hi20 = (T+32'h800)>>12 and lo12 = T[11:0]:
  - LUI t0 = {hi20, 12'h2b7}
  - ADDI t0,t0 = {lo12, 20'h28293}
  - JR t0 = 32'h0002_8067
- Content, mode 0 (T = RAM_BASE): w0 = LUI, w1 = ADDI, w2 = JR, all other words = 0.
- Content, mode 1 (T = XIP_BASE):
  - w0 = 32'h0100_006f (j +0x10); w1 = w2 = 32'h0000_0013 (nop); w3 = CFG_WORD
  - w4 = LUI, w5 = ADDI, w6 = JR; all other words = 0.
- ROM content is constant; no storage beyond the response register.
- Reset mid-transaction: a pending response is dropped and rsp_valid=0 after the reset edge. No response is ever issued for a command accepted in the reset cycle.
- Illegal DW (not 32 or 64) or DP*4 > 2^AW is an elaboration error.

Decomposition:
- Package sirv_bootrom_pkg holds:
  - opcode constants (OPC_LUI, OPC_OPIMM, OPC_JALR, NOP, J_PLUS_16)
  - REG_T0 = 5
  - constant functions enc_lui(rd, imm), enc_addi(rd, rs, imm), enc_jalr(rd, rs, imm)
  - BOOT_MODE enumeration
- Sub-module sirv_bootrom_table: purely combinational word lookup by index, generated from the parameters. It also produces an in-range flag.
- Top level holds the ICB handshake and the response register.

Test Plan:
- Mode 0, DW=32, RAM_BASE=8000_0000: read 0x000/0x004/0x008/0x00C -> 8000_02b7, 0002_8293, 0002_8067, 0000_0000, all err=0.
- Mode 1, DW=32, XIP_BASE=2040_0000, CFG_WORD=6661: read 0x00..0x18 -> 0100_006f, 13, 13, 6661, 2040_02b7, 0002_8293, 0002_8067.
- RAM_BASE=8000_0800 (lo12 sign case): w0 = 8000_12b7, w1 = 8002_8293; a simulated LUI+ADDI yields 8000_0800.
- DW=64, mode 0: read 0x000 -> 0002_8293_8000_02b7; read 0x008 -> 0000_0000_0002_8067.
- Back-pressure: 3 back-to-back reads with rsp_ready low for 4 cycles -> cmd_ready low, rsp held stable; then 1 rsp per cycle, in order, no loss or duplicate.
- Errors and reset:
  - write to 0x0 -> err=1, rdata=0
  - DP=16 with read 0x040 -> err=1
  - rst_n low while rsp_valid is high -> rsp_valid=0 on the next edge

Source files
------------

// File: rtl/sirv_bootrom_pkg.sv
// sirv_bootrom_pkg
// Shared definitions for the ICB boot ROM:
//   - RISC-V opcode and fixed-instruction constants
//   - constant functions that encode the LUI / ADDI / JALR boot sequence
//   - the boot-mode enumeration
package sirv_bootrom_pkg;

  typedef enum logic [0:0] {
    BOOT_RAM = 1'b0,  // jump straight to RAM_BASE
    BOOT_XIP = 1'b1   // config header, then jump to XIP_BASE
  } boot_mode_e;

  localparam logic [6:0]  OPC_LUI   = 7'h37;
  localparam logic [6:0]  OPC_OPIMM = 7'h13;
  localparam logic [6:0]  OPC_JALR  = 7'h67;
  localparam logic [31:0] NOP       = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] J_PLUS_16 = 32'h0100_006f;  // jal x0, +0x10
  localparam logic [4:0]  REG_T0    = 5'd5;

  function automatic logic [31:0] enc_lui(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, OPC_LUI};
  endfunction

  function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs,
                                           input logic [11:0] imm);
    return {imm, rs, 3'b000, rd, OPC_OPIMM};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs,
                                           input logic [11:0] imm);
    return {imm, rs, 3'b000, rd, OPC_JALR};
  endfunction

endpackage

// File: rtl/sirv_bootrom_table.sv
// sirv_bootrom_table
// Combinational ROM lookup. Content is fixed at elaboration from the boot
// parameters; nothing here is stored.
// Ports:
//   word_idx  in  AW-2  index of the lowest 32-bit word of the beat
//   beat      out DW    DW/32 consecutive words, lowest word in bits [31:0]
//   in_range  out 1     word_idx lies inside the implemented depth DP
module sirv_bootrom_table
  import sirv_bootrom_pkg::*;
#(
  parameter int          AW        = 12,
  parameter int          DW        = 32,
  parameter int          DP        = 1024,
  parameter int          BOOT_MODE = 0,
  parameter logic [31:0] RAM_BASE  = 32'h8000_0000,
  parameter logic [31:0] XIP_BASE  = 32'h2040_0000,
  parameter logic [31:0] CFG_WORD  = 32'h0000_6661
) (
  input  logic [AW-3:0] word_idx,
  output logic [DW-1:0] beat,
  output logic          in_range
);

  localparam logic [31:0] TARGET  = (BOOT_MODE == int'(BOOT_XIP)) ? XIP_BASE : RAM_BASE;
  // ADDI sign-extends its 12-bit immediate, so the upper part is rounded up
  // by 0x800 to cancel a negative low part.
  localparam logic [31:0] T_ROUND = TARGET + 32'h0000_0800;
  localparam logic [19:0] HI20    = T_ROUND[31:12];
  localparam logic [11:0] LO12    = TARGET[11:0];

  localparam logic [31:0] LUI_W   = enc_lui(REG_T0, HI20);
  localparam logic [31:0] ADDI_W  = enc_addi(REG_T0, REG_T0, LO12);
  localparam logic [31:0] JR_W    = enc_jalr(5'd0, REG_T0, 12'd0);

  function automatic logic [31:0] word_at(input logic [31:0] idx);
    logic [31:0] w;
    w = '0;
    if (idx < 32'(DP)) begin
      if (BOOT_MODE == int'(BOOT_XIP)) begin
        case (idx)
          32'd0:   w = J_PLUS_16;
          32'd1:   w = NOP;
          32'd2:   w = NOP;
          32'd3:   w = CFG_WORD;
          32'd4:   w = LUI_W;
          32'd5:   w = ADDI_W;
          32'd6:   w = JR_W;
          default: w = '0;
        endcase
      end else begin
        case (idx)
          32'd0:   w = LUI_W;
          32'd1:   w = ADDI_W;
          32'd2:   w = JR_W;
          default: w = '0;
        endcase
      end
    end
    return w;
  endfunction

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; a missed branch would otherwise infer a latch.
  always_comb begin
    beat = '0;
    for (int i = 0; i < DW / 32; i++) begin
      beat[i*32 +: 32] = word_at(32'(word_idx) + 32'(i));
    end
  end

  assign in_range = (32'(word_idx) < 32'(DP));

endmodule

// File: rtl/sirv_bootrom_icb.sv
// sirv_bootrom_icb
// Parametrised boot ROM behind an ICB slave port with a one-entry registered
// response (1-cycle latency, full throughput, back-pressurable).
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   i_icb_cmd_valid/ready      command handshake (ready = ~rsp_valid | rsp_ready)
//   i_icb_cmd_addr   [AW]      byte offset within the ROM
//   i_icb_cmd_read             1 = read, 0 = write (writes answer err=1)
//   i_icb_cmd_wdata/wmask      unused, ROM is read-only
//   i_icb_rsp_valid/ready      response handshake
//   i_icb_rsp_rdata  [DW]      read data (0 on error)
//   i_icb_rsp_err              write or out-of-range access
module sirv_bootrom_icb
  import sirv_bootrom_pkg::*;
#(
  parameter int          AW        = 12,
  parameter int          DW        = 32,
  parameter int          DP        = 1024,
  parameter int          BOOT_MODE = 0,
  parameter logic [31:0] RAM_BASE  = 32'h8000_0000,
  parameter logic [31:0] XIP_BASE  = 32'h2040_0000,
  parameter logic [31:0] CFG_WORD  = 32'h0000_6661
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_icb_cmd_valid,
  output logic            i_icb_cmd_ready,
  input  logic [AW-1:0]   i_icb_cmd_addr,
  input  logic            i_icb_cmd_read,
  input  logic [DW-1:0]   i_icb_cmd_wdata,
  input  logic [DW/8-1:0] i_icb_cmd_wmask,
  output logic            i_icb_rsp_valid,
  input  logic            i_icb_rsp_ready,
  output logic [DW-1:0]   i_icb_rsp_rdata,
  output logic            i_icb_rsp_err
);

  if ((DW != 32 && DW != 64) || (DP * 4 > (1 << AW))) begin : g_bad_params
    $error("sirv_bootrom_icb: DW must be 32 or 64 and DP*4 must fit in 2^AW bytes");
  end

  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q,   rsp_err_d;

  logic [AW-3:0]   word_idx;
  logic [DW-1:0]   beat;
  logic            in_range;
  logic            cmd_accept;

  // Byte lanes inside a beat are not selectable; the whole beat is returned.
  logic            unused_inputs;
  assign unused_inputs = ^{i_icb_cmd_wdata, i_icb_cmd_wmask, i_icb_cmd_addr[2:0]};

  // A 64-bit beat always starts on an even word.
  assign word_idx = (DW == 64) ? {i_icb_cmd_addr[AW-1:3], 1'b0} : i_icb_cmd_addr[AW-1:2];

  sirv_bootrom_table #(
    .AW        (AW),
    .DW        (DW),
    .DP        (DP),
    .BOOT_MODE (BOOT_MODE),
    .RAM_BASE  (RAM_BASE),
    .XIP_BASE  (XIP_BASE),
    .CFG_WORD  (CFG_WORD)
  ) u_table (
    .word_idx (word_idx),
    .beat     (beat),
    .in_range (in_range)
  );

  // The register can take a new command whenever it is empty or is being
  // drained this cycle, giving one command per cycle with no bubble.
  assign i_icb_cmd_ready = ~rsp_valid_q | i_icb_rsp_ready;
  assign cmd_accept      = i_icb_cmd_valid & i_icb_cmd_ready;

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (cmd_accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = ~i_icb_cmd_read | ~in_range;
      rsp_rdata_d = (i_icb_cmd_read & in_range) ? beat : '0;
    end else if (i_icb_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its inputs from before the edge, independent of statement order.
  // Reset is synchronous; a command arriving in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign i_icb_rsp_valid = rsp_valid_q;
  assign i_icb_rsp_rdata = rsp_rdata_q;
  assign i_icb_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_sirv_bootrom_icb.sv
// Directed bench for sirv_bootrom_icb. Five configurations share one command
// stream; each test inspects the instance relevant to it.
module tb_sirv_bootrom_icb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic [11:0] cmd_addr;
  logic        cmd_read;
  logic        rsp_ready;
  logic [31:0] wdata32 = '0;
  logic [3:0]  wmask32 = '0;
  logic [63:0] wdata64 = '0;
  logic [7:0]  wmask64 = '0;

  logic        m0_cr, m0_v, m0_e;  logic [31:0] m0_d;
  logic        m1_cr, m1_v, m1_e;  logic [31:0] m1_d;
  logic        sg_cr, sg_v, sg_e;  logic [31:0] sg_d;
  logic        dp_cr, dp_v, dp_e;  logic [31:0] dp_d;
  logic        w6_cr, w6_v, w6_e;  logic [63:0] w6_d;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sirv_bootrom_icb #(.BOOT_MODE(0)) u_m0 (
    .clk(clk), .rst_n(rst_n), .i_icb_cmd_valid(cmd_valid), .i_icb_cmd_ready(m0_cr),
    .i_icb_cmd_addr(cmd_addr), .i_icb_cmd_read(cmd_read), .i_icb_cmd_wdata(wdata32),
    .i_icb_cmd_wmask(wmask32), .i_icb_rsp_valid(m0_v), .i_icb_rsp_ready(rsp_ready),
    .i_icb_rsp_rdata(m0_d), .i_icb_rsp_err(m0_e));

  sirv_bootrom_icb #(.BOOT_MODE(1), .XIP_BASE(32'h2040_0000), .CFG_WORD(32'h0000_6661)) u_m1 (
    .clk(clk), .rst_n(rst_n), .i_icb_cmd_valid(cmd_valid), .i_icb_cmd_ready(m1_cr),
    .i_icb_cmd_addr(cmd_addr), .i_icb_cmd_read(cmd_read), .i_icb_cmd_wdata(wdata32),
    .i_icb_cmd_wmask(wmask32), .i_icb_rsp_valid(m1_v), .i_icb_rsp_ready(rsp_ready),
    .i_icb_rsp_rdata(m1_d), .i_icb_rsp_err(m1_e));

  sirv_bootrom_icb #(.BOOT_MODE(0), .RAM_BASE(32'h8000_0800)) u_sg (
    .clk(clk), .rst_n(rst_n), .i_icb_cmd_valid(cmd_valid), .i_icb_cmd_ready(sg_cr),
    .i_icb_cmd_addr(cmd_addr), .i_icb_cmd_read(cmd_read), .i_icb_cmd_wdata(wdata32),
    .i_icb_cmd_wmask(wmask32), .i_icb_rsp_valid(sg_v), .i_icb_rsp_ready(rsp_ready),
    .i_icb_rsp_rdata(sg_d), .i_icb_rsp_err(sg_e));

  sirv_bootrom_icb #(.DP(16)) u_dp (
    .clk(clk), .rst_n(rst_n), .i_icb_cmd_valid(cmd_valid), .i_icb_cmd_ready(dp_cr),
    .i_icb_cmd_addr(cmd_addr), .i_icb_cmd_read(cmd_read), .i_icb_cmd_wdata(wdata32),
    .i_icb_cmd_wmask(wmask32), .i_icb_rsp_valid(dp_v), .i_icb_rsp_ready(rsp_ready),
    .i_icb_rsp_rdata(dp_d), .i_icb_rsp_err(dp_e));

  sirv_bootrom_icb #(.DW(64)) u_w6 (
    .clk(clk), .rst_n(rst_n), .i_icb_cmd_valid(cmd_valid), .i_icb_cmd_ready(w6_cr),
    .i_icb_cmd_addr(cmd_addr), .i_icb_cmd_read(cmd_read), .i_icb_cmd_wdata(wdata64),
    .i_icb_cmd_wmask(wmask64), .i_icb_rsp_valid(w6_v), .i_icb_rsp_ready(rsp_ready),
    .i_icb_rsp_rdata(w6_d), .i_icb_rsp_err(w6_e));

  // Stimulus only: present one command with rsp_ready high for one edge,
  // leaving the bench 1 time unit after that edge.
  task automatic send(input logic [11:0] a, input logic rd);
    cmd_valid = 1'b1; cmd_addr = a; cmd_read = rd; rsp_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({m0_v, m0_d, m0_e} !== {1'b0, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: got v=%b d=%h e=%b, want v=0 d=00000000 e=0", m0_v, m0_d, m0_e);
    end
    rst_n = 1'b1; #1;
    checks++;
    if (m0_cr !== 1'b1) begin
      failures++;
      $display("FAIL reset_cmd_ready: got %b, want 1", m0_cr);
    end
  endtask

  task automatic test_mode0();
    logic [31:0] exp [4] = '{32'h8000_02b7, 32'h0002_8293, 32'h0002_8067, 32'h0000_0000};
    for (int i = 0; i < 4; i++) begin
      send(12'(i * 4), 1'b1);
      checks++;
      if ({m0_v, m0_d, m0_e} !== {1'b1, exp[i], 1'b0}) begin
        failures++;
        $display("FAIL mode0_w%0d: got v=%b d=%h e=%b, want v=1 d=%h e=0", i, m0_v, m0_d, m0_e, exp[i]);
      end
    end
  endtask

  task automatic test_mode1();
    logic [31:0] exp [7] = '{32'h0100_006f, 32'h0000_0013, 32'h0000_0013, 32'h0000_6661,
                             32'h2040_02b7, 32'h0002_8293, 32'h0002_8067};
    for (int i = 0; i < 7; i++) begin
      send(12'(i * 4), 1'b1);
      checks++;
      if ({m1_v, m1_d, m1_e} !== {1'b1, exp[i], 1'b0}) begin
        failures++;
        $display("FAIL mode1_w%0d: got v=%b d=%h e=%b, want v=1 d=%h e=0", i, m1_v, m1_d, m1_e, exp[i]);
      end
    end
  endtask

  task automatic test_sign_lo12();
    logic [31:0] w0, w1, t0;
    send(12'h000, 1'b1); w0 = sg_d;
    checks++;
    if (w0 !== 32'h8000_12b7) begin
      failures++;
      $display("FAIL sign_lui: got %h, want 800012b7", w0);
    end
    send(12'h004, 1'b1); w1 = sg_d;
    checks++;
    if (w1 !== 32'h8002_8293) begin
      failures++;
      $display("FAIL sign_addi: got %h, want 80028293", w1);
    end
    // Execute the pair: LUI loads imm<<12, ADDI adds the sign-extended imm12.
    t0 = {w0[31:12], 12'h000} + {{20{w1[31]}}, w1[31:20]};
    checks++;
    if (t0 !== 32'h8000_0800) begin
      failures++;
      $display("FAIL sign_exec: got %h, want 80000800", t0);
    end
  endtask

  task automatic test_dw64();
    send(12'h000, 1'b1);
    checks++;
    if ({w6_v, w6_d, w6_e} !== {1'b1, 64'h0002_8293_8000_02b7, 1'b0}) begin
      failures++;
      $display("FAIL dw64_beat0: got v=%b d=%h e=%b, want v=1 d=0002829380 0002b7 e=0", w6_v, w6_d, w6_e);
    end
    send(12'h008, 1'b1);
    checks++;
    if ({w6_v, w6_d, w6_e} !== {1'b1, 64'h0000_0000_0002_8067, 1'b0}) begin
      failures++;
      $display("FAIL dw64_beat1: got v=%b d=%h e=%b, want v=1 d=0000000000028067 e=0", w6_v, w6_d, w6_e);
    end
    // addr[2] does not select a half-beat.
    send(12'h004, 1'b1);
    checks++;
    if (w6_d !== 64'h0002_8293_8000_02b7) begin
      failures++;
      $display("FAIL dw64_addr2_ignored: got %h, want 0002829380 0002b7", w6_d);
    end
  endtask

  task automatic test_errors();
    send(12'h000, 1'b0);
    checks++;
    if ({m0_v, m0_d, m0_e} !== {1'b1, 32'h0, 1'b1}) begin
      failures++;
      $display("FAIL write_err: got v=%b d=%h e=%b, want v=1 d=00000000 e=1", m0_v, m0_d, m0_e);
    end
    send(12'h040, 1'b1);
    checks++;
    if ({dp_v, dp_d, dp_e} !== {1'b1, 32'h0, 1'b1}) begin
      failures++;
      $display("FAIL dp16_oor: got v=%b d=%h e=%b, want v=1 d=00000000 e=1", dp_v, dp_d, dp_e);
    end
    checks++;
    if (m0_e !== 1'b0) begin
      failures++;
      $display("FAIL dp1024_inrange: got e=%b, want e=0", m0_e);
    end
    send(12'h03c, 1'b1);
    checks++;
    if (dp_e !== 1'b0) begin
      failures++;
      $display("FAIL dp16_last_word: got e=%b, want e=0", dp_e);
    end
    @(posedge clk); #1;  // drain
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [3] = '{32'h8000_02b7, 32'h0002_8293, 32'h0002_8067};
    rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 12'h000;
    @(posedge clk); #1;
    cmd_addr = 12'h004;
    checks++;
    if ({m0_v, m0_d, m0_cr} !== {1'b1, exp[0], 1'b0}) begin
      failures++;
      $display("FAIL bp_first: got v=%b d=%h cr=%b, want v=1 d=%h cr=0", m0_v, m0_d, m0_cr, exp[0]);
    end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({m0_v, m0_d, m0_e, m0_cr} !== {1'b1, exp[0], 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL bp_hold%0d: got v=%b d=%h e=%b cr=%b, want v=1 d=%h e=0 cr=0",
                 c, m0_v, m0_d, m0_e, m0_cr, exp[0]);
      end
    end
    rsp_ready = 1'b1; #1;
    checks++;
    if (m0_cr !== 1'b1) begin
      failures++;
      $display("FAIL bp_ready_release: got cr=%b, want 1", m0_cr);
    end
    for (int k = 1; k < 3; k++) begin
      @(posedge clk); #1;
      if (k == 1) cmd_addr = 12'h008;
      else cmd_valid = 1'b0;
      checks++;
      if ({m0_v, m0_d} !== {1'b1, exp[k]}) begin
        failures++;
        $display("FAIL bp_order%0d: got v=%b d=%h, want v=1 d=%h", k, m0_v, m0_d, exp[k]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (m0_v !== 1'b0) begin
      failures++;
      $display("FAIL bp_drained: got v=%b, want 0", m0_v);
    end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 12'h000;
    @(posedge clk); #1;
    // Response now pending; assert reset together with a fresh command.
    rst_n = 1'b0; cmd_addr = 12'h004;
    @(posedge clk); #1;
    checks++;
    if ({m0_v, m0_d, m0_e} !== {1'b0, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid: got v=%b d=%h e=%b, want v=0 d=00000000 e=0", m0_v, m0_d, m0_e);
    end
    rst_n = 1'b1; cmd_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (m0_v !== 1'b0) begin
      failures++;
      $display("FAIL reset_cycle_cmd_dropped: got v=%b, want 0", m0_v);
    end
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_read = 1'b1; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_mode0();
    test_mode1();
    test_sign_lo12();
    test_dw64();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
